// File: rtl/alu_out_uart_tracer_pkg.sv
// Shared FSM state type and UART framing constants for the ALU-result tracer.
package tracer_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tracer_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   BIT_IDX_W       = $clog2(UART_DATA_BITS);
endpackage

// File: rtl/alu_out_uart_tracer_fifo.sv
// Synchronous capture FIFO; full/empty judged on pre-edge count, so a pop never frees a slot for a same-edge push.
// Read data is the combinational head (zero latency); writes at full and reads at empty are ignored.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trace_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/alu_out_uart_tracer.sv
// Captures ALU results into a FIFO and serialises them as UART 8N1; push-to-start latency 1 cycle, frame 10*CLKS_PER_BIT+1.
// No backpressure: pushes at full are dropped and flag sticky overflow. ALU_TRACER_DEDUP_EN suppresses repeated values.
module alu_out_uart_tracer
  import tracer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  data_in,
  input  logic                        data_valid,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("alu_out_uart_tracer: CLKS_PER_BIT must be >= 2");
  end

  localparam int                   BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(UART_DATA_BITS - 1);

  tracer_state_t                state, state_nxt;
  logic [BAUD_W-1:0]            baud_cnt, baud_nxt;
  logic [BIT_IDX_W-1:0]         bit_idx, bit_nxt;
  logic [UART_DATA_BITS-1:0]    shreg, shreg_nxt;
  logic                         baud_done;

  logic                         push_req;
  logic                         pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [7:0]                   head;

`ifdef ALU_TRACER_DEDUP_EN
  logic [7:0] last_val;
  logic       last_vld;

  assign push_req = data_valid && !(last_vld && (data_in == last_val));

  // Only values actually written count as "accepted"; drops at full leave the compare value alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val <= 8'h00;
      last_vld <= 1'b0;
    end else if (push_req && !fifo_full) begin
      last_val <= data_in;
      last_vld <= 1'b1;
    end
  end
`else
  assign push_req = data_valid;
`endif

  trace_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (data_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= shreg_nxt;
    end
  end

  assign baud_done = (baud_cnt == BAUD_LAST);

  // tx is decoded purely from registered state, so reset forces it high asynchronously.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    pop       = 1'b0;
    tx        = UART_IDLE_LEVEL;
    if (state != IDLE) begin
      baud_nxt = baud_done ? '0 : baud_cnt + 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_nxt = head;
          state_nxt = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_done) state_nxt = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (baud_done) begin
          shreg_nxt = shreg >> 1;
          if (bit_idx == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        tx = UART_IDLE_LEVEL;
        if (baud_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || !fifo_empty;
endmodule
